// File: rtl/kernel_cc_sched_pkg.sv
// kernel_cc_sched_pkg: shared types and helpers for the kernel_cc start scheduler.
//   - state_e   : launcher FSM states
//   - *_DEF     : default sizing, widths derived from the counts
//   - rr_pick() : round-robin search over up to RR_MAX requesters
package kernel_cc_sched_pkg;

  localparam int RR_MAX           = 8;
  localparam int RR_IDX_W         = 3;
  localparam int NUM_REQ_DEF      = 4;
  localparam int MAX_INFLIGHT_DEF = 4;
  localparam int ID_W_DEF         = $clog2(NUM_REQ_DEF);
  localparam int CNT_W_DEF        = $clog2(MAX_INFLIGHT_DEF + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_START = 1'b1
  } state_e;

  typedef struct packed {
    logic                vld;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] searching upward from ptr, wrapping modulo n.
  // Walked from the far end so the hit closest to ptr is written last.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   req,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int                  n);
    rr_pick_t   p;
    logic [3:0] j;
    p = '0;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      if (i < n) begin
        j = {1'b0, ptr} + 4'(i);
        if (j >= 4'(n)) j = j - 4'(n);
        if (req[j[2:0]]) begin
          p.vld = 1'b1;
          p.idx = j[2:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/kernel_cc_start_sched_if.sv
// kernel_cc_start_sched_if: requester, start-FIFO and downstream ap_* signals.
//   master : scheduler side (drives grants, FIFO strobes, ap_start, status)
//   slave  : environment side (requesters, FIFO, downstream process)
interface kernel_cc_start_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 3
);
  logic [NUM_REQ-1:0] req_start;
  logic [NUM_REQ-1:0] req_grant;
  logic               fifo_full_n;
  logic               fifo_write;
  logic [ID_W-1:0]    fifo_din;
  logic               fifo_empty_n;
  logic               fifo_read;
  logic [ID_W-1:0]    fifo_dout;
  logic               ap_start;
  logic               ap_ready;
  logic               ap_done;
  logic [ID_W-1:0]    ap_id;
  logic [CNT_W-1:0]   inflight;
  logic               err_underflow;

  modport master (
    input  req_start, fifo_full_n, fifo_empty_n, fifo_dout, ap_ready, ap_done,
    output req_grant, fifo_write, fifo_din, fifo_read, ap_start, ap_id,
           inflight, err_underflow
  );

  modport slave (
    output req_start, fifo_full_n, fifo_empty_n, fifo_dout, ap_ready, ap_done,
    input  req_grant, fifo_write, fifo_din, fifo_read, ap_start, ap_id,
           inflight, err_underflow
  );
endinterface

// File: rtl/kernel_cc_rr_arbiter.sv
// kernel_cc_rr_arbiter: zero-latency round-robin share of the start FIFO write port.
//   clk, reset   : clock, synchronous active-high reset
//   req_start    : per-requester level request
//   fifo_full_n  : FIFO can take a token
//   req_grant    : one-hot grant (combinational)
//   fifo_write   : write strobe, fifo_din = granted id
module kernel_cc_rr_arbiter
  import kernel_cc_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = ID_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_start,
  input  logic               fifo_full_n,
  output logic [NUM_REQ-1:0] req_grant,
  output logic               fifo_write,
  output logic [ID_W-1:0]    fifo_din
);

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [RR_MAX-1:0] req_pad;
  rr_pick_t          pick;

  always_comb begin
    req_pad              = '0;
    req_pad[NUM_REQ-1:0] = req_start;
    pick                 = rr_pick(req_pad, RR_IDX_W'(rr_ptr_q), NUM_REQ);
    req_grant            = '0;
    fifo_write           = 1'b0;
    fifo_din             = '0;
    rr_ptr_d             = rr_ptr_q;
    if (!reset && fifo_full_n && pick.vld) begin
      req_grant  = NUM_REQ'(1) << pick.idx;
      fifo_write = 1'b1;
      fifo_din   = ID_W'(pick.idx);
      // Pointer moves just past the winner so it has lowest priority next.
      rr_ptr_d   = (pick.idx == RR_IDX_W'(NUM_REQ - 1)) ? '0 : ID_W'(pick.idx + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/kernel_cc_start_sched.sv
// kernel_cc_start_sched: start-token scheduler for the kernel_cc dataflow region.
//   clk, reset : clock, synchronous active-high reset
//   bus        : requesters -> round-robin FIFO writes; FIFO pops -> ap_start/ap_ready
//                launcher with an in-flight credit counter and sticky underflow flag
//   Optional KERNEL_CC_SCHED_STATS_EN adds launch_cnt (accepted launches) and
//   stall_cnt (IDLE cycles blocked only by the credit limit).
module kernel_cc_start_sched
  import kernel_cc_sched_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int ID_W         = ID_W_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef KERNEL_CC_SCHED_STATS_EN
  output logic [31:0]             launch_cnt,
  output logic [31:0]             stall_cnt,
`endif
  kernel_cc_start_sched_if.master bus
);

  state_e           state_q, state_d;
  logic             ap_start_q, ap_start_d;
  logic [ID_W-1:0]  ap_id_q, ap_id_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             err_q, err_d;
  logic             pop, acc, at_limit;

  kernel_cc_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_start   (bus.req_start),
    .fifo_full_n (bus.fifo_full_n),
    .req_grant   (bus.req_grant),
    .fifo_write  (bus.fifo_write),
    .fifo_din    (bus.fifo_din)
  );

  assign at_limit = (inflight_q >= CNT_W'(MAX_INFLIGHT));

  always_comb begin
    state_d    = state_q;
    ap_id_d    = ap_id_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    pop        = 1'b0;
    acc        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.fifo_empty_n && !at_limit) begin
          pop     = 1'b1;
          ap_id_d = bus.fifo_dout;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bus.ap_ready) begin
          acc     = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
    // Launch and completion in one cycle cancel out.
    if (acc && !bus.ap_done) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!acc && bus.ap_done) begin
      if (inflight_q == '0) err_d = 1'b1;
      else                  inflight_d = inflight_q - 1'b1;
    end
    ap_start_d = (state_d == S_START);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ap_start_q <= 1'b0;
      ap_id_q    <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ap_start_q <= ap_start_d;
      ap_id_q    <= ap_id_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign bus.fifo_read     = pop && !reset;
  assign bus.ap_start      = ap_start_q;
  assign bus.ap_id         = ap_id_q;
  assign bus.inflight      = inflight_q;
  assign bus.err_underflow = err_q;

`ifdef KERNEL_CC_SCHED_STATS_EN
  logic [31:0] launch_cnt_q, launch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    launch_cnt_d = launch_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (acc) launch_cnt_d = launch_cnt_q + 32'd1;
    if (state_q == S_IDLE && bus.fifo_empty_n && at_limit) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      launch_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      launch_cnt_q <= launch_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign launch_cnt = launch_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_kernel_cc_start_sched.sv
// tb_kernel_cc_start_sched: directed self-checking bench for kernel_cc_start_sched.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_kernel_cc_start_sched;
  import kernel_cc_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_run  = 0;
  int   n_fail = 0;
  int   tokens, pops;

  always #5 clk = ~clk;

  kernel_cc_start_sched_if #(.NUM_REQ(4), .ID_W(2), .CNT_W(3)) bus ();

`ifdef KERNEL_CC_SCHED_STATS_EN
  logic [31:0] launch_cnt, stall_cnt;
  kernel_cc_start_sched #(.NUM_REQ(4), .ID_W(2), .MAX_INFLIGHT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .launch_cnt(launch_cnt), .stall_cnt(stall_cnt), .bus(bus));
`else
  kernel_cc_start_sched #(.NUM_REQ(4), .ID_W(2), .MAX_INFLIGHT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); reset = 1'b0;
  endtask

  // Emulates a FIFO holding `tokens` entries; counts pops.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      bus.fifo_empty_n = (tokens > 0);
      #1;
      if (bus.fifo_read === 1'b1) begin pops++; tokens--; end
      cyc();
    end
    bus.fifo_empty_n = (tokens > 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_start = 4'hF; bus.fifo_full_n = 1'b1; bus.fifo_empty_n = 1'b1;
    cyc(); cyc(); #1;
    n_run++; if (bus.req_grant !== 4'h0) begin n_fail++; $display("FAIL reset_grant got %h want 0", bus.req_grant); end
    n_run++; if (bus.fifo_write !== 1'b0) begin n_fail++; $display("FAIL reset_write got %b want 0", bus.fifo_write); end
    n_run++; if (bus.fifo_read !== 1'b0) begin n_fail++; $display("FAIL reset_read got %b want 0", bus.fifo_read); end
    n_run++; if (bus.ap_start !== 1'b0 || bus.ap_id !== 2'd0) begin n_fail++; $display("FAIL reset_ap got start=%b id=%0d want 0/0", bus.ap_start, bus.ap_id); end
    n_run++; if (bus.inflight !== 3'd0 || bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_cnt got inflight=%0d err=%b want 0/0", bus.inflight, bus.err_underflow); end
    n_run++; if (dut.u_arb.rr_ptr_q !== 2'd0) begin n_fail++; $display("FAIL reset_ptr got %0d want 0", dut.u_arb.rr_ptr_q); end
    bus.req_start = 4'h0; bus.fifo_empty_n = 1'b0;
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    bus.req_start = 4'hF; bus.fifo_full_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      eg = 4'b0001 << (k % 4);
      n_run++;
      if (bus.req_grant !== eg || bus.fifo_din !== 2'(k % 4) || bus.fifo_write !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_grant[%0d] got grant=%b din=%0d wr=%b want %b/%0d/1", k, bus.req_grant, bus.fifo_din, bus.fifo_write, eg, k % 4);
      end
      cyc();
    end
    bus.req_start = 4'h0;
  endtask

  task automatic test_full_fifo();
    bus.req_start = 4'b0100; bus.fifo_full_n = 1'b0;
    #1;
    n_run++; if (bus.req_grant !== 4'h0 || bus.fifo_write !== 1'b0) begin n_fail++; $display("FAIL full_nogrant got grant=%b wr=%b want 0/0", bus.req_grant, bus.fifo_write); end
    cyc(); cyc(); #1;
    n_run++; if (dut.u_arb.rr_ptr_q !== 2'd1) begin n_fail++; $display("FAIL full_ptr_hold got %0d want 1", dut.u_arb.rr_ptr_q); end
    bus.fifo_full_n = 1'b1; #1;
    n_run++; if (bus.req_grant !== 4'b0100 || bus.fifo_din !== 2'd2 || bus.fifo_write !== 1'b1) begin n_fail++; $display("FAIL full_resume got grant=%b din=%0d want 0100/2", bus.req_grant, bus.fifo_din); end
    cyc();
    bus.req_start = 4'h0; #1;
    n_run++; if (dut.u_arb.rr_ptr_q !== 2'd3) begin n_fail++; $display("FAIL full_ptr_adv got %0d want 3", dut.u_arb.rr_ptr_q); end
  endtask

  task automatic test_single_launch();
    do_reset();
    bus.fifo_empty_n = 1'b1; bus.fifo_dout = 2'd3; bus.ap_ready = 1'b0;
    #1;
    n_run++; if (bus.fifo_read !== 1'b1 || bus.ap_start !== 1'b0) begin n_fail++; $display("FAIL launch_pop got read=%b start=%b want 1/0", bus.fifo_read, bus.ap_start); end
    cyc();
    bus.fifo_empty_n = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) bus.ap_ready = 1'b1;
      #1;
      n_run++;
      if (bus.ap_start !== 1'b1 || bus.fifo_read !== 1'b0) begin n_fail++; $display("FAIL launch_start[%0d] got start=%b read=%b want 1/0", c, bus.ap_start, bus.fifo_read); end
      cyc();
    end
    bus.ap_ready = 1'b0; #1;
    n_run++; if (bus.ap_start !== 1'b0 || bus.ap_id !== 2'd3 || bus.inflight !== 3'd1) begin n_fail++; $display("FAIL launch_end got start=%b id=%0d inflight=%0d want 0/3/1", bus.ap_start, bus.ap_id, bus.inflight); end
  endtask

  task automatic test_credit_limit();
    do_reset();
    bus.ap_ready = 1'b1; bus.ap_done = 1'b0; bus.fifo_dout = 2'd1;
    tokens = 6; pops = 0;
    run(16); #1;
    n_run++; if (pops != 4 || bus.inflight !== 3'd4 || bus.fifo_read !== 1'b0) begin n_fail++; $display("FAIL credit_block got pops=%0d inflight=%0d read=%b want 4/4/0", pops, bus.inflight, bus.fifo_read); end
    bus.ap_done = 1'b1; cyc(); bus.ap_done = 1'b0;
    run(8); #1;
    n_run++; if (pops != 5 || bus.inflight !== 3'd4 || tokens != 1) begin n_fail++; $display("FAIL credit_resume got pops=%0d inflight=%0d want 5/4", pops, bus.inflight); end
`ifdef KERNEL_CC_SCHED_STATS_EN
    n_run++; if (launch_cnt !== 32'd5) begin n_fail++; $display("FAIL stats_launch got %0d want 5", launch_cnt); end
`endif
    bus.ap_ready = 1'b0; bus.fifo_empty_n = 1'b0;
  endtask

  task automatic test_ready_done();
    do_reset();
    bus.ap_ready = 1'b1; tokens = 2; pops = 0;
    run(6); #1;
    n_run++; if (bus.inflight !== 3'd2) begin n_fail++; $display("FAIL rd_setup got inflight=%0d want 2", bus.inflight); end
    bus.ap_ready = 1'b0; tokens = 1;
    run(1);
    bus.ap_ready = 1'b1; bus.ap_done = 1'b1; #1;
    n_run++; if (bus.ap_start !== 1'b1) begin n_fail++; $display("FAIL rd_start got %b want 1", bus.ap_start); end
    cyc();
    bus.ap_ready = 1'b0; bus.ap_done = 1'b0; #1;
    n_run++; if (bus.inflight !== 3'd2 || bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL rd_both got inflight=%0d err=%b want 2/0", bus.inflight, bus.err_underflow); end
    bus.ap_done = 1'b1; cyc(); cyc(); bus.ap_done = 1'b0; #1;
    n_run++; if (bus.inflight !== 3'd0 || bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL rd_drain got inflight=%0d err=%b want 0/0", bus.inflight, bus.err_underflow); end
    bus.ap_done = 1'b1; cyc(); bus.ap_done = 1'b0; #1;
    n_run++; if (bus.err_underflow !== 1'b1 || bus.inflight !== 3'd0) begin n_fail++; $display("FAIL underflow got err=%b inflight=%0d want 1/0", bus.err_underflow, bus.inflight); end
    cyc(); cyc(); #1;
    n_run++; if (bus.err_underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky got %b want 1", bus.err_underflow); end
    do_reset(); #1;
    n_run++; if (bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_clear got %b want 0", bus.err_underflow); end
  endtask

  task automatic test_reset_mid_start();
    do_reset();
    bus.ap_ready = 1'b1; bus.fifo_full_n = 1'b1; tokens = 3; pops = 0;
    bus.req_start = 4'b0001;
    run(1);
    bus.req_start = 4'h0;
    run(6);
    bus.ap_ready = 1'b0; tokens = 1;
    run(1); #1;
    n_run++; if (bus.ap_start !== 1'b1 || bus.inflight !== 3'd3 || dut.u_arb.rr_ptr_q !== 2'd1) begin n_fail++; $display("FAIL mid_pre got start=%b inflight=%0d ptr=%0d want 1/3/1", bus.ap_start, bus.inflight, dut.u_arb.rr_ptr_q); end
    reset = 1'b1; cyc(); #1;
    n_run++; if (bus.ap_start !== 1'b0 || bus.inflight !== 3'd0) begin n_fail++; $display("FAIL mid_reset got start=%b inflight=%0d want 0/0", bus.ap_start, bus.inflight); end
    n_run++; if (dut.state_q !== S_IDLE || dut.u_arb.rr_ptr_q !== 2'd0) begin n_fail++; $display("FAIL mid_state got state=%0d ptr=%0d want 0/0", dut.state_q, dut.u_arb.rr_ptr_q); end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.req_start = '0; bus.fifo_full_n = 1'b1; bus.fifo_empty_n = 1'b0;
    bus.fifo_dout = '0; bus.ap_ready = 1'b0; bus.ap_done = 1'b0;
    tokens = 0; pops = 0;
    test_reset();
    test_round_robin();
    test_full_fifo();
    test_single_launch();
    test_credit_limit();
    test_ready_done();
    test_reset_mid_start();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
